// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the elastic pipeline register.
// Occupancy sizing and parameter sanity helpers.
package pipe_reg_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 2;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit cfg_ok(input int data_w, input int depth);
        return (data_w >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/pipe_reg_hs_if.sv
// Valid/ready handshake bundle carrying one payload word.
// The producer side uses master, the consumer side uses slave.
interface pipe_reg_hs_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_reg_stage.sv
// One pipeline slot: valid bit plus payload register.
// Reset beats flush beats load; flush leaves the payload untouched.
module pipe_reg_stage #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic              i_src_valid,
    input  logic [DATA_W-1:0] i_src_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_v;
    logic [DATA_W-1:0] r_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= 1'b0;
            r_d <= PRESET_VAL;
        end else if (i_flush) begin
            r_v <= 1'b0;
        end else if (i_load) begin
            r_v <= i_src_valid;
            if (i_src_valid) begin
                r_d <= i_src_data;
            end
        end
    end

    assign o_valid = r_v;
    assign o_data  = r_d;

endmodule

// File: rtl/pipe_reg_hs.sv
// Elastic DEPTH-stage pipeline register with bubble collapsing,
// global enable, synchronous flush and an occupancy counter.
module pipe_reg_hs
    import pipe_reg_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                DEPTH      = DEF_DEPTH,
    parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    pipe_reg_hs_if.slave              up,
    pipe_reg_hs_if.master             dn,
    output logic [occ_w(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    if (!cfg_ok(DATA_W, DEPTH)) begin : g_bad_cfg
        $error("pipe_reg_hs: DATA_W and DEPTH must both be >= 1");
    end

    logic              w_go;
    logic              w_rdy [DEPTH+1];
    logic              w_v   [DEPTH];
    logic [DATA_W-1:0] w_d   [DEPTH];
    logic              w_sv  [DEPTH];
    logic [DATA_W-1:0] w_sd  [DEPTH];
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [OCC_W-1:0]  r_occ;

    assign w_go         = en & ~flush;
    assign w_rdy[DEPTH] = dn.ready & w_go;

    // A stage can load when it is empty or its content moves on.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_src_in
            assign w_sv[i] = up.valid;
            assign w_sd[i] = up.data;
        end else begin : g_src_prev
            assign w_sv[i] = w_v[i-1];
            assign w_sd[i] = w_d[i-1];
        end

        assign w_rdy[i] = w_go & (~w_v[i] | w_rdy[i+1]);

        pipe_reg_stage #(
            .DATA_W     (DATA_W),
            .PRESET_VAL (PRESET_VAL)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .i_load      (w_rdy[i]),
            .i_flush     (flush),
            .i_src_valid (w_sv[i]),
            .i_src_data  (w_sd[i]),
            .o_valid     (w_v[i]),
            .o_data      (w_d[i])
        );
    end

    assign up.ready = w_rdy[0];
    assign dn.valid = w_v[DEPTH-1];
    assign dn.data  = w_d[DEPTH-1];

    assign w_in_xfer  = up.valid & w_rdy[0];
    assign w_out_xfer = w_v[DEPTH-1] & w_rdy[DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_occ <= '0;
        end else begin
            unique case ({w_in_xfer, w_out_xfer})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Directed bench for pipe_reg_hs (DATA_W=8, DEPTH=3, PRESET_VAL=A5):
// a vector table plus streaming and enable-stall sequences.
module tb_pipe_reg_hs;

    localparam int DW = 8;
    localparam int DP = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       flush;
    logic [1:0] occupancy;

    pipe_reg_hs_if #(.DATA_W(DW)) up_if ();
    pipe_reg_hs_if #(.DATA_W(DW)) dn_if ();

    pipe_reg_hs #(
        .DATA_W     (DW),
        .DEPTH      (DP),
        .PRESET_VAL (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .up        (up_if),
        .dn        (dn_if),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        bit         chk;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic [1:0] occ;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, e, f, v, input logic [7:0] d,
                       input logic o, input bit c, input logic ir,
                       input logic ov, input logic [7:0] od,
                       input logic [1:0] oc);
        vec_t t;
        t = '{r, e, f, v, d, o, c, ir, ov, od, oc};
        vecs.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   first;
        int   last;
        int   nxt;
        int   pushed;
        int   pops;
        logic mv [DP];
        logic [7:0] md [DP];
        int   mocc;

        // rst en fl iv id ordy | chk ir ov od occ (pre-edge values)
        add(1,1,0,0,8'h00,0, 0, 0,0,8'h00,0);
        add(1,1,0,0,8'h00,0, 1, 1,0,8'hA5,0);
        add(0,1,0,1,8'h11,0, 1, 1,0,8'hA5,0);
        add(0,1,0,0,8'h00,0, 1, 1,0,8'hA5,1);
        add(0,1,0,1,8'h22,0, 1, 1,0,8'hA5,1);
        add(0,1,0,1,8'h33,0, 1, 1,1,8'h11,2);
        add(0,1,0,1,8'h44,0, 1, 0,1,8'h11,3);
        add(0,1,0,1,8'h44,1, 1, 1,1,8'h11,3);
        add(0,1,0,1,8'h55,1, 1, 1,1,8'h22,3);
        add(0,1,0,0,8'h00,1, 1, 1,1,8'h33,3);
        add(0,1,1,1,8'h66,1, 1, 0,1,8'h44,2);
        add(0,1,0,0,8'h00,1, 1, 1,0,8'h44,0);
        add(1,1,1,0,8'h00,1, 1, 0,0,8'h44,0);
        add(0,1,0,0,8'h00,1, 1, 1,0,8'hA5,0);
        add(0,1,0,1,8'h77,0, 1, 1,0,8'hA5,0);
        add(0,0,1,1,8'h88,0, 1, 0,0,8'hA5,1);
        add(0,1,0,0,8'h00,0, 1, 1,0,8'hA5,0);

        foreach (vecs[k]) begin
            rst         = vecs[k].rst;
            en          = vecs[k].en;
            flush       = vecs[k].fl;
            up_if.valid = vecs[k].iv;
            up_if.data  = vecs[k].id;
            dn_if.ready = vecs[k].ordy;
            #1;
            if (vecs[k].chk) begin
                chk($sformatf("v%0d in_ready", k), 32'(up_if.ready),
                    32'(vecs[k].ir));
                chk($sformatf("v%0d out_valid", k), 32'(dn_if.valid),
                    32'(vecs[k].ov));
                chk($sformatf("v%0d out_data", k), 32'(dn_if.data),
                    32'(vecs[k].od));
                chk($sformatf("v%0d occupancy", k), 32'(occupancy),
                    32'(vecs[k].occ));
            end
            tick();
        end

        // Streaming: 0x01..0x10 back-to-back with out_ready held high.
        rst = 0; en = 1; flush = 0; dn_if.ready = 1;
        first = -1; last = -1; nxt = 1;
        for (int k = 0; k < 26; k++) begin
            up_if.valid = (k < 16);
            up_if.data  = 8'(k + 1);
            #1;
            if (k < 16) chk("stream in_ready", 32'(up_if.ready), 1);
            if (k >= 3 && k <= 16)
                chk("stream occupancy", 32'(occupancy), 3);
            if (dn_if.valid === 1'b1) begin
                if (first < 0) first = k;
                else chk("stream gap", k, last + 1);
                last = k;
                chk("stream data", 32'(dn_if.data), nxt);
                nxt++;
            end
            tick();
        end
        chk("stream first cycle", first, 3);
        chk("stream count", nxt - 1, 16);

        // Enable stall for 4 cycles mid-stream against a delay-line model.
        for (int i = 0; i < DP; i++) begin
            mv[i] = 1'b0;
            md[i] = 8'h00;
        end
        pushed = 0; pops = 0;
        for (int k = 0; k < 24; k++) begin
            en          = !(k >= 4 && k < 8);
            up_if.valid = (pushed < 10);
            up_if.data  = 8'(8'h40 + pushed);
            #1;
            mocc = 0;
            for (int i = 0; i < DP; i++) mocc += int'(mv[i]);
            chk("en in_ready", 32'(up_if.ready), 32'(en));
            chk("en out_valid", 32'(dn_if.valid), 32'(mv[DP-1]));
            chk("en occupancy", 32'(occupancy), mocc);
            if (mv[DP-1]) chk("en out_data", 32'(dn_if.data), 32'(md[DP-1]));
            if (en) begin
                if (mv[DP-1]) pops++;
                for (int i = DP - 1; i > 0; i--) begin
                    mv[i] = mv[i-1];
                    if (mv[i-1]) md[i] = md[i-1];
                end
                mv[0] = up_if.valid;
                if (up_if.valid) begin
                    md[0] = up_if.data;
                    pushed++;
                end
            end
            tick();
        end
        chk("en words delivered", pops, 10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
